// File: rtl/med_pkg.sv
// Shared definitions for the streaming median filter: window limits, FSM states and
// the half-span helper that sets the centre-tap offset in pixels.
package med_pkg;

  localparam int MAX_WIN = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // Distance in pixels from the centre tap to the outermost tap on one side.
  function automatic int half_span(input int win, input int stride);
    return ((win - 1) / 2) * stride;
  endfunction

endpackage

// File: rtl/med_sort_net.sv
// Odd-even transposition sorter over WIN taps with a register after the first half of
// the rounds; the centre element of the sorted vector is the median.
module med_sort_net #(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [WIN*DATA_WIDTH-1:0] taps_i,
  output logic [DATA_WIDTH-1:0]     med_o
);

  localparam int MID = WIN / 2;

  logic [DATA_WIDTH-1:0] tap_w  [WIN];
  logic [DATA_WIDTH-1:0] pre_w  [WIN];
  logic [DATA_WIDTH-1:0] mid_q  [WIN];
  logic [DATA_WIDTH-1:0] post_w [WIN];

  generate
    for (genvar gi = 0; gi < WIN; gi++) begin : g_unpack
      assign tap_w[gi] = taps_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Rounds alternate between even and odd pairings; WIN rounds fully sort WIN values.
  always_comb begin
    logic [DATA_WIDTH-1:0] tmp;
    tmp   = '0;
    pre_w = tap_w;
    for (int r = 0; r < MID; r++) begin
      for (int i = r % 2; i + 1 < WIN; i += 2) begin
        if (pre_w[i] > pre_w[i+1]) begin
          tmp        = pre_w[i];
          pre_w[i]   = pre_w[i+1];
          pre_w[i+1] = tmp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_q <= '{default: '0};
    end else if (en_i) begin
      mid_q <= pre_w;
    end
  end

  always_comb begin
    logic [DATA_WIDTH-1:0] tmp;
    tmp    = '0;
    post_w = mid_q;
    for (int r = MID; r < WIN; r++) begin
      for (int i = r % 2; i + 1 < WIN; i += 2) begin
        if (post_w[i] > post_w[i+1]) begin
          tmp         = post_w[i];
          post_w[i]   = post_w[i+1];
          post_w[i+1] = tmp;
        end
      end
    end
  end

  assign med_o = post_w[MID];

endmodule

// File: rtl/med_stream_filt.sv
// Row-wise streaming median filter: D-deep shift buffer, line FSM and a two-stage
// sort/select pipeline shared by filtered and bypassed (border) pixels.
module med_stream_filt
  import med_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 3,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sol,
  input  logic                  in_eol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sol,
  output logic                  out_eol,
  output logic                  err
);

  localparam int HS = half_span(WIN, STRIDE);
  localparam int D  = 2 * HS + 1;
  localparam int PW = $clog2(D + 1);
  localparam int IW = $clog2(D);
  localparam logic [PW-1:0] D_P = PW'(D);

  state_t                state_q, state_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [DATA_WIDTH-1:0] pix_q [D];
  logic [DATA_WIDTH-1:0] pix_d [D];
  logic [D-1:0]          vld_q, vld_d, sol_q, sol_d, eol_q, eol_d;
  logic                  err_q, err_d;

  logic                  emit, emit_byp, emit_sol, emit_eol;
  logic [DATA_WIDTH-1:0] emit_data;
  logic [IW-1:0]         fl_idx;

  logic                  s1_vld_q, s1_byp_q, s1_sol_q, s1_eol_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  out_valid_q, out_sol_q, out_eol_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                      advance, accept;
  logic [WIN*DATA_WIDTH-1:0] taps_w;
  logic [DATA_WIDTH-1:0]     med_w;

  assign advance  = out_ready | ~out_valid_q;
  assign in_ready = advance & (state_q != FLUSH) & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    pix_d     = pix_q;
    vld_d     = vld_q;
    sol_d     = sol_q;
    eol_d     = eol_q;
    err_d     = err_q;
    emit      = 1'b0;
    emit_byp  = 1'b1;
    emit_data = '0;
    emit_sol  = 1'b0;
    emit_eol  = 1'b0;
    fl_idx    = '0;
    if (accept) begin
      if (!in_sol && state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        if (in_sol && state_q == RUN) err_d = 1'b1;
        // A new sol invalidates everything still buffered from an unfinished line.
        for (int i = D - 1; i >= 1; i--) begin
          pix_d[i] = pix_q[i-1];
          vld_d[i] = vld_q[i-1] & ~in_sol;
          sol_d[i] = sol_q[i-1];
          eol_d[i] = eol_q[i-1];
        end
        pix_d[0]  = in_data;
        vld_d[0]  = 1'b1;
        sol_d[0]  = in_sol;
        eol_d[0]  = in_eol;
        pos_d     = in_sol ? PW'(1) : ((pos_q == D_P) ? pos_q : pos_q + 1'b1);
        state_d   = in_eol ? FLUSH : RUN;
        emit      = vld_d[HS];
        emit_byp  = (pos_d != D_P);
        emit_data = pix_d[HS];
        emit_sol  = sol_d[HS];
        emit_eol  = eol_d[HS];
      end
    end else if (state_q == FLUSH && advance) begin
      // Oldest remaining pixel sits at the highest valid index below the centre.
      for (int i = 0; i < HS; i++) begin
        if (vld_q[i]) fl_idx = IW'(i);
      end
      emit          = 1'b1;
      emit_data     = pix_q[fl_idx];
      emit_sol      = sol_q[fl_idx];
      emit_eol      = eol_q[fl_idx];
      vld_d[fl_idx] = 1'b0;
      if (fl_idx == '0) begin
        state_d = IDLE;
        pos_d   = '0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIN; gi++) begin : g_taps
      assign taps_w[gi*DATA_WIDTH +: DATA_WIDTH] = pix_d[gi*STRIDE];
    end
  endgenerate

  med_sort_net #(
    .DATA_WIDTH(DATA_WIDTH),
    .WIN       (WIN)
  ) u_sort (
    .clk   (clk),
    .rst   (rst),
    .en_i  (advance),
    .taps_i(taps_w),
    .med_o (med_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      pix_q       <= '{default: '0};
      vld_q       <= '0;
      sol_q       <= '0;
      eol_q       <= '0;
      err_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_sol_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      sol_q   <= sol_d;
      eol_q   <= eol_d;
      err_q   <= err_d;
      if (advance) begin
        s1_vld_q    <= emit;
        s1_byp_q    <= emit_byp;
        s1_data_q   <= emit_data;
        s1_sol_q    <= emit_sol;
        s1_eol_q    <= emit_eol;
        out_valid_q <= s1_vld_q;
        out_data_q  <= s1_byp_q ? s1_data_q : med_w;
        out_sol_q   <= s1_vld_q & s1_sol_q;
        out_eol_q   <= s1_vld_q & s1_eol_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sol   = out_sol_q;
  assign out_eol   = out_eol_q;
  assign err       = err_q;

endmodule

// File: tb/tb_med_stream_filt.sv
// Drives three filter configurations (3/1, 3/2, 5/1) with directed and random lines and
// compares every output pixel against a whole-line median model.
module tb_med_stream_filt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int data;
    bit sol;
    bit eol;
  } pix_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int median_of(input int taps[$]);
    int s[$];
    s = taps;
    s.sort();
    return s[s.size() / 2];
  endfunction

  // Expected output of one line; an unfinished line only yields pixels whose right
  // neighbourhood arrived before the line was abandoned.
  function automatic void model_line(input int px[$], input bit complete, input int win,
                                     input int stride, output pix_t res[$]);
    int   hs, len;
    pix_t p;
    int   taps[$];
    res = {};
    hs  = ((win - 1) / 2) * stride;
    len = px.size();
    for (int j = 0; j < len; j++) begin
      if (complete || j + hs <= len - 1) begin
        p.data = px[j];
        if (j >= hs && j + hs <= len - 1) begin
          taps = {};
          for (int k = -(win - 1) / 2; k <= (win - 1) / 2; k++) taps.push_back(px[j + k*stride]);
          p.data = median_of(taps);
        end
        p.sol = (j == 0);
        p.eol = complete && (j == len - 1);
        res.push_back(p);
      end
    end
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 2) ? 5 : 3;
    localparam int S = (gi == 1) ? 2 : 1;

    logic       rst, in_valid, in_ready, in_sol, in_eol;
    logic       out_valid, out_ready, out_sol, out_eol, err;
    logic [7:0] in_data, out_data;

    med_stream_filt #(.DATA_WIDTH(8), .WIN(W), .STRIDE(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sol   (in_sol),
      .in_eol   (in_eol),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sol  (out_sol),
      .out_eol  (out_eol),
      .err      (err)
    );

    pix_t       src[$], act[$], exp_q[$];
    int         cur[$];
    bit         open_line, err_exp, done_b;
    int         cyc, rdy_pct, vld_pct, stall_from, stall_to;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_sol, prev_eol;
    int         spec_in[$], spec_out[$];

    function automatic string tg(input string t);
      return $sformatf("c%0d.%s", gi, t);
    endfunction

    task automatic model_accept(input pix_t p);
      pix_t r[$];
      if (p.sol) begin
        if (open_line) begin
          model_line(cur, 1'b0, W, S, r);
          foreach (r[i]) exp_q.push_back(r[i]);
          err_exp = 1'b1;
        end
        cur       = {p.data};
        open_line = 1'b1;
      end else if (!open_line) begin
        err_exp = 1'b1;
      end else begin
        cur.push_back(p.data);
      end
      if (open_line && p.eol) begin
        model_line(cur, 1'b1, W, S, r);
        foreach (r[i]) exp_q.push_back(r[i]);
        cur       = {};
        open_line = 1'b0;
      end
    endtask

    task automatic step();
      pix_t a;
      @(negedge clk);
      if (cyc >= stall_from && cyc < stall_to) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (src.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
        in_valid = 1'b1;
        in_data  = 8'(src[0].data);
        in_sol   = src[0].sol;
        in_eol   = src[0].eol;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sol   = 1'($urandom);
        in_eol   = 1'($urandom);
      end
      #1;
      if (prev_stall) begin
        check(tg("hold_valid"), out_valid, 1);
        check(tg("hold_data"), out_data, prev_data);
        check(tg("hold_flags"), {out_sol, out_eol}, {prev_sol, prev_eol});
      end
      if (out_valid && !out_ready) check(tg("stall_in_ready"), in_ready, 0);
      if (in_valid && in_ready) model_accept(src.pop_front());
      if (out_valid && out_ready) begin
        a.data = out_data;
        a.sol  = out_sol;
        a.eol  = out_eol;
        act.push_back(a);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sol   = out_sol;
      prev_eol   = out_eol;
      cyc++;
    endtask

    task automatic send_all();
      int budget;
      budget = 4000;
      while (src.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      if (src.size() > 0) begin
        check(tg("send_timeout"), src.size(), 0);
        src = {};
      end
    endtask

    task automatic drain();
      int budget;
      rdy_pct = 100;
      budget  = 300;
      while (act.size() < exp_q.size() && budget > 0) begin
        step();
        budget--;
      end
      repeat (8) step();
    endtask

    task automatic compare(input string t);
      check(tg({t, "_count"}), act.size(), exp_q.size());
      for (int i = 0; i < act.size() && i < exp_q.size(); i++) begin
        $display("[TB] c%0d %s #%0d data=%0d sol=%0b eol=%0b (model %0d %0b %0b)", gi, t, i,
                 act[i].data, act[i].sol, act[i].eol, exp_q[i].data, exp_q[i].sol, exp_q[i].eol);
        check(tg({t, "_data"}), act[i].data, exp_q[i].data);
        check(tg({t, "_sol"}), act[i].sol, exp_q[i].sol);
        check(tg({t, "_eol"}), act[i].eol, exp_q[i].eol);
      end
      act   = {};
      exp_q = {};
    endtask

    task automatic lit_check(input string t, input int lit[$]);
      check(tg({t, "_count"}), act.size(), lit.size());
      for (int i = 0; i < lit.size() && i < act.size(); i++) begin
        check(tg({t, "_data"}), act[i].data, lit[i]);
        check(tg({t, "_sol"}), act[i].sol, (i == 0));
        check(tg({t, "_eol"}), act[i].eol, (i == lit.size() - 1));
      end
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
      #1;
      check(tg("rst_in_ready"), in_ready, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check(tg("rst_out"), {out_valid, out_sol, out_eol, err}, 4'b0000);
      check(tg("rst_data"), out_data, 0);
      cur        = {};
      open_line  = 1'b0;
      err_exp    = 1'b0;
      act        = {};
      exp_q      = {};
      prev_stall = 1'b0;
    endtask

    task automatic push_line(input int len, input bit with_eol);
      pix_t p;
      for (int i = 0; i < len; i++) begin
        p.data = int'($urandom_range(0, 255));
        p.sol  = (i == 0);
        p.eol  = with_eol && (i == len - 1);
        src.push_back(p);
      end
    endtask

    task automatic push_list(input int vals[$]);
      pix_t p;
      foreach (vals[i]) begin
        p.data = vals[i];
        p.sol  = (i == 0);
        p.eol  = (i == vals.size() - 1);
        src.push_back(p);
      end
    endtask

    initial begin
      pix_t p;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sol = 1'b0; in_eol = 1'b0; out_ready = 1'b1;
      done_b = 1'b0; cyc = 0; rdy_pct = 100; vld_pct = 100; stall_from = -1; stall_to = -1;
      case (gi)
        0: begin spec_in = {10, 50, 20, 30, 40}; spec_out = {10, 20, 30, 30, 40}; end
        1: begin
          spec_in  = {10, 100, 50, 200, 20, 150, 30, 250};
          spec_out = {10, 100, 20, 150, 30, 200, 30, 250};
        end
        default: begin spec_in = {9, 1, 8, 2, 7, 3, 6}; spec_out = {9, 1, 7, 3, 6, 3, 6}; end
      endcase
      do_reset();

      // Reference line, with a three-cycle downstream stall in the middle for 3/1.
      if (gi == 0) begin stall_from = cyc + 4; stall_to = cyc + 7; end
      push_list(spec_in);
      send_all();
      drain();
      lit_check("spec_line", spec_out);
      compare("spec_model");

      // Single-pixel line followed by an ordinary line.
      p.data = 77; p.sol = 1'b1; p.eol = 1'b1;
      src.push_back(p);
      push_line(6, 1'b1);
      send_all();
      drain();
      check(tg("one_px_data"), (act.size() > 0) ? act[0].data : -1, 77);
      check(tg("one_px_flags"), (act.size() > 0) ? {act[0].sol, act[0].eol} : 2'b00, 2'b11);
      compare("one_px");
      check(tg("err_clean"), err, err_exp);

      // Line abandoned after three pixels by a fresh sol.
      push_line(3, 1'b0);
      push_line(6, 1'b1);
      send_all();
      drain();
      compare("abort");
      check(tg("err_abort"), err, 1);
      do_reset();
      check(tg("err_cleared"), err, 0);

      // Stray non-sol pixel while idle is discarded and flags an error.
      p.data = 5; p.sol = 1'b0; p.eol = 1'b0;
      src.push_back(p);
      push_line(5, 1'b1);
      send_all();
      drain();
      compare("stray");
      check(tg("err_stray"), err, err_exp);
      do_reset();

      // Random traffic with back-pressure, occasional strays and aborted lines.
      rdy_pct = 60; vld_pct = 70;
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 11) == 0) begin
          p.data = int'($urandom_range(0, 255)); p.sol = 1'b0; p.eol = 1'b0;
          src.push_back(p);
        end
        push_line(int'($urandom_range(1, 12)), ($urandom_range(0, 9) != 0));
        send_all();
        rdy_pct = 60;
      end
      push_line(4, 1'b1);
      send_all();
      drain();
      compare("random");
      check(tg("err_random"), err, err_exp);
      done_b = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 60000; c++) begin
      if (g_cfg[0].done_b && g_cfg[1].done_b && g_cfg[2].done_b) break;
      @(posedge clk);
    end
    check("all_done", {g_cfg[0].done_b, g_cfg[1].done_b, g_cfg[2].done_b}, 3'b111);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
